// File: rtl/dc_store_pkg.sv
// Shared constants and helpers for the multi-channel duty-cycle store.
// Optional peak tracking is enabled with the DC_STORE_PEAK_EN macro.
package dc_store_pkg;

   localparam logic MODE_CLEAR = 1'b0;
   localparam logic MODE_DECAY = 1'b1;

   // Prescaler counter width; never narrower than one bit so PRESCALE=1 still builds.
   function automatic int presc_width(input int prescale);
      int w;
      w = $clog2(prescale);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/dc_store_chan.sv
// One duty-cycle channel: saturating run-length counter with sat/sat_event flags.
// DC_STORE_PEAK_EN adds a running-maximum peak register per channel.
module dc_store_chan
   import dc_store_pkg::*;
#(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             upd,
   input  logic             mode,
   input  logic             current,
   input  logic             clr,
`ifdef DC_STORE_PEAK_EN
   input  logic             peak_clr,
   output logic [WIDTH-1:0] peak,
`endif
   output logic [WIDTH-1:0] count,
   output logic             sat,
   output logic             sat_event
);

   localparam logic [WIDTH-1:0] MAX = '1;

   logic [WIDTH-1:0] count_d, count_q;
   logic             sat_event_d, sat_event_q;

   // Clear beats everything; otherwise only an update slot may move the count.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (upd) begin
         if (current) begin
            if (count_q != MAX) count_d = count_q + WIDTH'(1);
         end else if (mode == MODE_CLEAR) begin
            count_d = '0;
         end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
         end
      end
      sat_event_d = (count_d == MAX) && (count_q != MAX);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q     <= '0;
         sat_event_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         sat_event_q <= sat_event_d;
      end
   end

   assign count     = count_q;
   assign sat       = (count_q == MAX);
   assign sat_event = sat_event_q;

`ifdef DC_STORE_PEAK_EN
   logic [WIDTH-1:0] peak_d, peak_q;

   always_comb begin
      peak_d = peak_q;
      if (peak_clr || (count_d > peak_q)) peak_d = count_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) peak_q <= '0;
      else     peak_q <= peak_d;
   end

   assign peak = peak_q;
`endif

endmodule

// File: rtl/dc_store_multi.sv
// Multi-channel duty-cycle store: shared prescaler and trigger gate feeding CH channels.
// Define DC_STORE_PEAK_EN to add peak_clr / dc_peak ports.
module dc_store_multi
   import dc_store_pkg::*;
#(
   parameter int CH       = 4,
   parameter int WIDTH    = 3,
   parameter int TRIG_W   = 3,
   parameter int PRESCALE = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CH-1:0]       current,
   input  logic [TRIG_W-1:0]   trigger,
   input  logic                mode,
   input  logic [CH-1:0]       clr,
`ifdef DC_STORE_PEAK_EN
   input  logic                peak_clr,
   output logic [CH*WIDTH-1:0] dc_peak,
`endif
   output logic [CH*WIDTH-1:0] dc_control,
   output logic [CH-1:0]       sat,
   output logic [CH-1:0]       sat_event
);

   localparam int            PW         = presc_width(PRESCALE);
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] presc_d, presc_q;
   logic          tick;
   logic          upd;

   // Prescaler free-runs regardless of trigger; the gate only masks the tick.
   always_comb begin
      tick    = (presc_q == PRESC_LAST);
      presc_d = tick ? '0 : presc_q + PW'(1);
      upd     = tick && (trigger == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) presc_q <= '0;
      else     presc_q <= presc_d;
   end

   for (genvar i = 0; i < CH; i++) begin : g_chan
      dc_store_chan #(
         .WIDTH(WIDTH)
      ) u_chan (
         .clk      (clk),
         .rst      (rst),
         .upd      (upd),
         .mode     (mode),
         .current  (current[i]),
         .clr      (clr[i]),
`ifdef DC_STORE_PEAK_EN
         .peak_clr (peak_clr),
         .peak     (dc_peak[i*WIDTH +: WIDTH]),
`endif
         .count    (dc_control[i*WIDTH +: WIDTH]),
         .sat      (sat[i]),
         .sat_event(sat_event[i])
      );
   end

endmodule

// File: tb/tb_dc_store_multi.sv
// Self-checking bench for dc_store_multi: scoreboarded per-cycle model plus directed scenarios.
// Peak checks are compiled in when DC_STORE_PEAK_EN is defined.
module tb_dc_store_multi;

   localparam int CH    = 2;
   localparam int WIDTH = 3;
   localparam int MAXV  = 7;

   logic                clk = 1'b0;
   logic                rst;
   logic [CH-1:0]       current;
   logic [2:0]          trigger;
   logic                mode;
   logic [CH-1:0]       clr;
   logic                peak_clr;
   logic [CH*WIDTH-1:0] dc_control;
   logic [CH-1:0]       sat, sat_event;

   logic [CH-1:0]       current4;
   logic [CH*WIDTH-1:0] dc4;
   logic [CH-1:0]       sat4, sat_event4;
   logic [CH*WIDTH-1:0] dc_peak_w;

   typedef struct packed {
      logic [CH*WIDTH-1:0] dc;
      logic [CH-1:0]       sat;
      logic [CH-1:0]       ev;
      logic [CH*WIDTH-1:0] peak;
   } exp_t;

   exp_t exp_q[$];
   int   m_cnt[CH];
   int   m_peak[CH];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   dc_store_multi #(.CH(CH), .WIDTH(WIDTH), .TRIG_W(3), .PRESCALE(1)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .current   (current),
      .trigger   (trigger),
      .mode      (mode),
      .clr       (clr),
`ifdef DC_STORE_PEAK_EN
      .peak_clr  (peak_clr),
      .dc_peak   (dc_peak_w),
`endif
      .dc_control(dc_control),
      .sat       (sat),
      .sat_event (sat_event)
   );

`ifndef DC_STORE_PEAK_EN
   assign dc_peak_w = '0;
`endif

   dc_store_multi #(.CH(CH), .WIDTH(WIDTH), .TRIG_W(3), .PRESCALE(4)) u_dut4 (
      .clk       (clk),
      .rst       (rst),
      .current   (current4),
      .trigger   (3'b000),
      .mode      (1'b0),
      .clr       (2'b00),
`ifdef DC_STORE_PEAK_EN
      .peak_clr  (1'b0),
      .dc_peak   (),
`endif
      .dc_control(dc4),
      .sat       (sat4),
      .sat_event (sat_event4)
   );

   // Drive one cycle, predict the post-edge state and queue it for the caller to check.
   task automatic drive_cycle(input logic [CH-1:0] cur, input logic [2:0] trig,
                              input logic md, input logic [CH-1:0] cl, input logic pc);
      exp_t e;
      int   nxt;
      current  = cur;
      trigger  = trig;
      mode     = md;
      clr      = cl;
      peak_clr = pc;
      e = '0;
      for (int i = 0; i < CH; i++) begin
         nxt = m_cnt[i];
         if (cl[i])                      nxt = 0;
         else if (trig != 3'd0)          nxt = m_cnt[i];
         else if (cur[i])                nxt = (m_cnt[i] == MAXV) ? MAXV : m_cnt[i] + 1;
         else if (!md)                   nxt = 0;
         else                            nxt = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
         e.ev[i]  = (nxt == MAXV) && (m_cnt[i] != MAXV);
         e.sat[i] = (nxt == MAXV);
         m_peak[i] = (pc || nxt > m_peak[i]) ? nxt : m_peak[i];
         m_cnt[i]  = nxt;
         e.dc[i*WIDTH +: WIDTH]   = WIDTH'(nxt);
         e.peak[i*WIDTH +: WIDTH] = WIDTH'(m_peak[i]);
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      current = '0; trigger = '0; mode = 1'b0; clr = '0; peak_clr = 1'b0; current4 = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < CH; i++) begin
         m_cnt[i]  = 0;
         m_peak[i] = 0;
      end
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      current = '0; trigger = '0; mode = 1'b0; clr = '0; peak_clr = 1'b0; current4 = '0;
      #3;
      total++;
      if (dc_control !== 6'd0 || dc4 !== 6'd0) begin
         bad++; $display("[TB] FAIL reset_dc got=%h/%h want=0/0", dc_control, dc4);
      end
      total++;
      if ({sat, sat_event, sat4, sat_event4} !== 8'd0) begin
         bad++; $display("[TB] FAIL reset_flags got=%b want=0", {sat, sat_event, sat4, sat_event4});
      end
      @(posedge clk);
      #1;
      do_reset();
   endtask

   task automatic test_ramp();
      exp_t e;
      for (int c = 1; c <= 9; c++) begin
         drive_cycle(2'b01, 3'd0, 1'b0, 2'b00, 1'b0);
         e = exp_q.pop_front();
         total++;
         if (dc_control !== e.dc) begin
            bad++; $display("[TB] FAIL ramp_dc cyc=%0d got=%h want=%h", c, dc_control, e.dc);
         end
         total++;
         if ({sat, sat_event} !== {e.sat, e.ev}) begin
            bad++; $display("[TB] FAIL ramp_flags cyc=%0d got=%b want=%b", c, {sat, sat_event}, {e.sat, e.ev});
         end
      end
      total++;
      if (dc_control !== {3'd0, 3'd7}) begin
         bad++; $display("[TB] FAIL ramp_final got=%h want=%h", dc_control, {3'd0, 3'd7});
      end
   endtask

   task automatic test_clear_mode();
      exp_t e;
      do_reset();
      for (int c = 0; c < 5; c++) begin
         drive_cycle(2'b01, 3'd0, 1'b0, 2'b00, 1'b0);
         e = exp_q.pop_front();
      end
      total++;
      if (dc_control[2:0] !== 3'd5) begin
         bad++; $display("[TB] FAIL clear_pre got=%0d want=5", dc_control[2:0]);
      end
      drive_cycle(2'b00, 3'd0, 1'b0, 2'b00, 1'b0);
      e = exp_q.pop_front();
      total++;
      if ({dc_control, sat, sat_event} !== {e.dc, e.sat, e.ev}) begin
         bad++; $display("[TB] FAIL clear_low got=%h want=%h", {dc_control, sat, sat_event}, {e.dc, e.sat, e.ev});
      end
   endtask

   task automatic test_decay();
      exp_t e;
      do_reset();
      for (int c = 0; c < 7; c++) begin
         drive_cycle(2'b01, 3'd0, 1'b0, 2'b00, 1'b0);
         e = exp_q.pop_front();
      end
      for (int c = 1; c <= 9; c++) begin
         drive_cycle(2'b00, 3'd0, 1'b1, 2'b00, 1'b0);
         e = exp_q.pop_front();
         total++;
         if ({dc_control, sat, sat_event} !== {e.dc, e.sat, e.ev}) begin
            bad++; $display("[TB] FAIL decay cyc=%0d got=%h want=%h", c, {dc_control, sat, sat_event}, {e.dc, e.sat, e.ev});
         end
      end
      for (int c = 1; c <= 8; c++) begin
         drive_cycle(2'b01, 3'd0, 1'b1, 2'b00, 1'b0);
         e = exp_q.pop_front();
         total++;
         if ({dc_control, sat, sat_event} !== {e.dc, e.sat, e.ev}) begin
            bad++; $display("[TB] FAIL reramp cyc=%0d got=%h want=%h", c, {dc_control, sat, sat_event}, {e.dc, e.sat, e.ev});
         end
      end
   endtask

   task automatic test_trigger();
      exp_t e;
      do_reset();
      for (int c = 0; c < 3; c++) begin
         drive_cycle(2'b01, 3'd0, 1'b0, 2'b00, 1'b0);
         e = exp_q.pop_front();
      end
      for (int c = 1; c <= 6; c++) begin
         drive_cycle(2'b01, (c <= 4) ? 3'b010 : 3'b000, 1'b0, 2'b00, 1'b0);
         e = exp_q.pop_front();
         total++;
         if (dc_control !== e.dc) begin
            bad++; $display("[TB] FAIL trigger cyc=%0d got=%h want=%h", c, dc_control, e.dc);
         end
      end
      total++;
      if (dc_control[2:0] !== 3'd5) begin
         bad++; $display("[TB] FAIL trigger_final got=%0d want=5", dc_control[2:0]);
      end
   endtask

   task automatic test_async_and_clr();
      exp_t e;
      do_reset();
      for (int c = 0; c < 6; c++) begin
         drive_cycle(2'b01, 3'd0, 1'b0, 2'b00, 1'b0);
         e = exp_q.pop_front();
      end
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (dc_control !== 6'd0) begin
         bad++; $display("[TB] FAIL async_rst got=%h want=0", dc_control);
      end
      do_reset();
      for (int c = 0; c < 2; c++) begin
         drive_cycle(2'b11, 3'd0, 1'b0, 2'b00, 1'b0);
         e = exp_q.pop_front();
      end
      drive_cycle(2'b11, 3'd0, 1'b0, 2'b01, 1'b0);
      e = exp_q.pop_front();
      total++;
      if (dc_control !== e.dc) begin
         bad++; $display("[TB] FAIL clr_prio got=%h want=%h", dc_control, e.dc);
      end
   endtask

   task automatic test_random();
      exp_t e;
      logic [2:0] trig;
      do_reset();
      for (int c = 1; c <= 60; c++) begin
         trig = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
         drive_cycle(2'($urandom), trig, 1'($urandom),
                     ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00,
                     ($urandom_range(0, 7) == 0));
         e = exp_q.pop_front();
         total++;
         if ({dc_control, sat, sat_event} !== {e.dc, e.sat, e.ev}) begin
            bad++; $display("[TB] FAIL random cyc=%0d got=%h want=%h", c, {dc_control, sat, sat_event}, {e.dc, e.sat, e.ev});
         end
`ifdef DC_STORE_PEAK_EN
         total++;
         if (dc_peak_w !== e.peak) begin
            bad++; $display("[TB] FAIL random_peak cyc=%0d got=%h want=%h", c, dc_peak_w, e.peak);
         end
`endif
      end
   endtask

   task automatic test_prescale();
      do_reset();
      current4 = 2'b01;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk);
         #1;
         total++;
         if (dc4[2:0] !== 3'(c / 4)) begin
            bad++; $display("[TB] FAIL prescale cyc=%0d got=%0d want=%0d", c, dc4[2:0], c / 4);
         end
      end
      current4 = '0;
   endtask

`ifdef DC_STORE_PEAK_EN
   task automatic test_peak();
      exp_t e;
      do_reset();
      for (int c = 0; c < 7; c++) begin
         drive_cycle(2'b01, 3'd0, 1'b0, 2'b00, 1'b0);
         e = exp_q.pop_front();
      end
      for (int c = 0; c < 3; c++) begin
         drive_cycle(2'b00, 3'd0, 1'b1, 2'b00, 1'b0);
         e = exp_q.pop_front();
      end
      total++;
      if (dc_peak_w[2:0] !== 3'd7 || dc_control[2:0] !== 3'd4) begin
         bad++; $display("[TB] FAIL peak_hold got=%0d/%0d want=7/4", dc_peak_w[2:0], dc_control[2:0]);
      end
      drive_cycle(2'b00, 3'd0, 1'b1, 2'b00, 1'b1);
      e = exp_q.pop_front();
      total++;
      if (dc_peak_w !== e.peak || dc_peak_w[2:0] !== 3'd3) begin
         bad++; $display("[TB] FAIL peak_clr got=%h want=%h", dc_peak_w, e.peak);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      test_reset();
      test_ramp();
      test_clear_mode();
      test_decay();
      test_trigger();
      test_async_and_clr();
      test_prescale();
`ifdef DC_STORE_PEAK_EN
      test_peak();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
